npc_ifu_fetch: RTL and testbench
================================

// Module: npc_ifu_fetch
// PURPOSE
//  Instruction fetch stage, upstream of IDU/EXU in the multi-cycle NPC core.
//  Fetches one 32-bit instruction per PC from the instruction memory port over a valid/ready
//  request and response handshake, then presents it to IDU with a valid/ready handshake.
//  After the instruction is consumed, it waits for the next PC from the PC-update handshake.
//  Only one fetch is in flight at any time.
// PARAMETERS
//  RESET_PC        32'h8000_0000  PC fetched first after reset
//  TIMEOUT_CYCLES  255            maximum wait cycles for a memory response before a fault (1..255)
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset: synchronous, active-high
//  imem_req_valid out  1   fetch request valid
//  imem_req_ready in   1   memory accepts request
//  imem_addr      out  32  fetch address; equals cur_pc while imem_req_valid is high
//  imem_rsp_valid in   1   response valid (one cycle per accepted request)
//  imem_rsp_err   in   1   bus error on this response
//  imem_rdata     in   32  instruction word
//  inst_valid     out  1   instruction valid to IDU
//  inst_ready     in   1   IDU accepts instruction
//  inst           out  32  instruction (32'h0000_0013 NOP when inst_fault=1)
//  inst_pc        out  32  PC of inst
//  inst_fault     out  1   fetch fault: misaligned, bus error, or timeout
//  pc_valid       in   1   next PC valid (from EXU/WB)
//  pc_ready       out  1   IFU accepts next PC
//  next_pc        in   32  next PC value
// BEHAVIOUR
//  - Reset: state=S_REQ, cur_pc=RESET_PC; imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0,
//    inst_fault=0, pc_ready=0, timeout counter=0. The memory port shares rst; no response
//    outstanding before reset survives it.
//  - Outputs are registered, except imem_req_valid and pc_ready, which decode the state.
//  - S_REQ: imem_req_valid=1 (only when cur_pc[1:0]==0). On req_valid&&req_ready, go to
//    S_WAIT and clear the counter.
//    If cur_pc[1:0]!=0: issue no request. Go to S_OUT with inst=NOP, inst_fault=1, inst_pc=cur_pc.
//  - S_WAIT: when rsp_valid, capture inst=rdata (or NOP if rsp_err), inst_fault=rsp_err,
//    inst_pc=cur_pc, then go to S_OUT.
//    Otherwise increment the counter. When counter==TIMEOUT_CYCLES-1, go to S_OUT with
//    inst_fault=1 and inst=NOP.
//  - S_OUT: inst_valid=1. inst, inst_pc and inst_fault stay stable until inst_valid&&inst_ready.
//    On that handshake, drop inst_valid and go to S_PC.
//  - S_PC: pc_ready=1. On pc_valid&&pc_ready: cur_pc<=next_pc, go to S_REQ.
//    A pc_valid arriving in any other state is ignored because pc_ready=0.
//  - Latency: request to inst_valid = response latency + 1 cycle.
//    With zero-wait memory (ready=1, rsp next cycle), the best-case loop is 4 cycles/instruction.
//  - rsp_valid outside S_WAIT is a protocol error. It is ignored; the assertion fires in simulation.
//  - A response in the same cycle the timeout expires is taken as a valid response; no fault.
//  - rst mid-fetch (any state): next cycle is S_REQ with cur_pc=RESET_PC; pending data is discarded.
// CONFIGURATION
//  Macro NPC_IFU_PERF_CNT_EN.
//  Defined: adds 64-bit counters perf_fetch_cnt (+1 per inst handshake) and
//  perf_stall_cnt (+1 per cycle in S_WAIT), plus output ports of the same names.
//  Both reset to 0 and wrap modulo 2^64.
//  Undefined: no counters and no ports. Behaviour is otherwise identical.
// TESTING
//  1 Reset then zero-wait mem returning 32'h0010_0093 -> imem_addr=32'h8000_0000; inst_valid on
//    cycle 3; inst=32'h0010_0093, inst_pc=32'h8000_0000, inst_fault=0.
//  2 inst_ready held 0 for 5 cycles -> inst_valid stays 1 and inst is unchanged;
//    pc_ready stays 0 until the handshake.
//  3 next_pc=32'h8000_0102 (misaligned) -> no imem_req_valid; inst=32'h0000_0013, inst_fault=1,
//    inst_pc=32'h8000_0102.
//  4 Memory never responds, TIMEOUT_CYCLES=4 -> inst_valid after 4 S_WAIT cycles with inst_fault=1.
//    Response on the 4th wait cycle -> no fault.
//  5 rsp_err=1 with rdata=32'hDEAD_BEEF -> inst=32'h0000_0013, inst_fault=1.
//  6 rst asserted in S_WAIT, then the loop runs -> next request addr=32'h8000_0000.
//    With NPC_IFU_PERF_CNT_EN, perf_fetch_cnt==N after N instructions.

Source files
------------

// File: rtl/npc_ifu_fetch_if.sv
// Fetch-stage bundle: instruction memory request/response, instruction to IDU,
// and next-PC handshake. The master side is the IFU; the slave side is its environment.
interface npc_ifu_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic        imem_rsp_err;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        pc_valid;
    logic        pc_ready;
    logic [31:0] next_pc;

    modport master (
        output imem_req_valid, imem_addr, inst_valid, inst, inst_pc, inst_fault, pc_ready,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_err, imem_rdata, inst_ready,
               pc_valid, next_pc
    );

    modport slave (
        input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc, inst_fault, pc_ready,
        output imem_req_ready, imem_rsp_valid, imem_rsp_err, imem_rdata, inst_ready,
               pc_valid, next_pc
    );
endinterface

// File: rtl/npc_ifu_fetch.sv
// NPC instruction fetch stage: one fetch in flight, REQ -> WAIT -> OUT -> PC loop.
// Optional macro NPC_IFU_PERF_CNT_EN adds 64-bit perf_fetch_cnt / perf_stall_cnt outputs.
module npc_ifu_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h8000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    npc_ifu_fetch_if.master      fetch
`ifdef NPC_IFU_PERF_CNT_EN
    ,
    output logic [63:0]          perf_fetch_cnt,
    output logic [63:0]          perf_stall_cnt
`endif
);
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2,
        S_PC   = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] cur_pc_reg, cur_pc_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [31:0] inst_reg, inst_next;
    logic [31:0] inst_pc_reg, inst_pc_next;
    logic        fault_reg, fault_next;
    logic        valid_reg, valid_next;
    logic        misaligned;

    assign misaligned = (cur_pc_reg[1:0] != 2'b00);

    // Request is gated by rst so the port stays quiet while reset is held.
    assign fetch.imem_req_valid = (state_reg == S_REQ) && !misaligned && !rst;
    assign fetch.pc_ready       = (state_reg == S_PC);
    assign fetch.imem_addr      = cur_pc_reg;
    assign fetch.inst_valid     = valid_reg;
    assign fetch.inst           = inst_reg;
    assign fetch.inst_pc        = inst_pc_reg;
    assign fetch.inst_fault     = fault_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_REQ;
            cur_pc_reg  <= RESET_PC;
            cnt_reg     <= 8'd0;
            inst_reg    <= 32'd0;
            inst_pc_reg <= 32'd0;
            fault_reg   <= 1'b0;
            valid_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cur_pc_reg  <= cur_pc_next;
            cnt_reg     <= cnt_next;
            inst_reg    <= inst_next;
            inst_pc_reg <= inst_pc_next;
            fault_reg   <= fault_next;
            valid_reg   <= valid_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cur_pc_next  = cur_pc_reg;
        cnt_next     = cnt_reg;
        inst_next    = inst_reg;
        inst_pc_next = inst_pc_reg;
        fault_next   = fault_reg;
        valid_next   = valid_reg;
        case (state_reg)
            S_REQ: begin
                if (misaligned) begin
                    inst_next    = NOP;
                    fault_next   = 1'b1;
                    inst_pc_next = cur_pc_reg;
                    valid_next   = 1'b1;
                    state_next   = S_OUT;
                end else if (fetch.imem_req_ready) begin
                    cnt_next   = 8'd0;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response wins over a timeout expiring in the same cycle.
                if (fetch.imem_rsp_valid) begin
                    inst_next    = fetch.imem_rsp_err ? NOP : fetch.imem_rdata;
                    fault_next   = fetch.imem_rsp_err;
                    inst_pc_next = cur_pc_reg;
                    valid_next   = 1'b1;
                    state_next   = S_OUT;
                end else if (cnt_reg == TMO_LAST) begin
                    inst_next    = NOP;
                    fault_next   = 1'b1;
                    inst_pc_next = cur_pc_reg;
                    valid_next   = 1'b1;
                    state_next   = S_OUT;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            S_OUT: begin
                if (fetch.inst_ready) begin
                    valid_next = 1'b0;
                    state_next = S_PC;
                end
            end
            S_PC: begin
                if (fetch.pc_valid) begin
                    cur_pc_next = fetch.next_pc;
                    state_next  = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

`ifdef NPC_IFU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= 64'd0;
            perf_stall_cnt <= 64'd0;
        end else begin
            if (state_reg == S_OUT && fetch.inst_ready) begin
                perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            end
            if (state_reg == S_WAIT) begin
                perf_stall_cnt <= perf_stall_cnt + 64'd1;
            end
        end
    end
`endif

    // A response is only legal while a fetch is outstanding; outside S_WAIT it is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(fetch.imem_rsp_valid && state_reg != S_WAIT));
        end
    end
endmodule

// File: tb/tb_npc_ifu_fetch.sv
// Directed bench for npc_ifu_fetch: memory model, stimulus thread, and a
// scoreboard monitor that pops expected instructions on each IDU handshake.
module tb_npc_ifu_fetch;
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    logic clk;
    logic rst;
    npc_ifu_fetch_if bus_if();
`ifdef NPC_IFU_PERF_CNT_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_stall_cnt;
`endif

    npc_ifu_fetch #(
        .RESET_PC      (32'h8000_0000),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .fetch(bus_if.master)
`ifdef NPC_IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        exp_q[$];
    logic [31:0] exp_addr = 32'h8000_0000;
    logic [31:0] mem_data = 32'h0;
    logic        mem_err  = 1'b0;
    logic        mem_silent = 1'b0;
    int          mem_lat  = 0;
    logic        pend     = 1'b0;
    int          wait_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] i, input logic [31:0] pc, input logic f);
        exp_t e;
        e.inst = i;
        e.pc = pc;
        e.fault = f;
        exp_q.push_back(e);
    endtask

    // Returns the cycle (counting the current one as 1) in which inst_valid is seen.
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!bus_if.inst_valid && cyc < 40) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        if (!bus_if.inst_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_inst_valid: got timeout expected inst_valid within 40 cycles");
        end
    endtask

    // Offer next_pc once pc_ready is up; returns in the S_REQ cycle that follows.
    task automatic give_pc(input logic [31:0] pc, input logic ready_after);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus_if.pc_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus_if.pc_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_pc_ready: got timeout expected pc_ready within 40 cycles");
        end
        bus_if.pc_valid = 1'b1;
        bus_if.next_pc  = pc;
        @(negedge clk);
        bus_if.pc_valid   = 1'b0;
        bus_if.inst_ready = ready_after;
    endtask

    // Memory model: responds mem_lat cycles after acceptance unless silent; cleared by rst.
    initial begin
        bus_if.imem_rsp_valid = 1'b0;
        bus_if.imem_rsp_err   = 1'b0;
        bus_if.imem_rdata     = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            bus_if.imem_rsp_valid = 1'b0;
            bus_if.imem_rsp_err   = 1'b0;
            bus_if.imem_rdata     = 32'h0;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (wait_cnt == 0) begin
                        bus_if.imem_rsp_valid = 1'b1;
                        bus_if.imem_rsp_err   = mem_err;
                        bus_if.imem_rdata     = mem_data;
                        pend = 1'b0;
                    end else begin
                        wait_cnt--;
                    end
                end
                if (bus_if.imem_req_valid && bus_if.imem_req_ready) begin
                    pend     = !mem_silent;
                    wait_cnt = mem_lat;
                end
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        logic        prev_valid;
        logic        prev_ready;
        logic [31:0] prev_inst;
        logic [31:0] prev_pc;
        logic        prev_fault;
        exp_t        e;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_inst  = 32'h0;
        prev_pc    = 32'h0;
        prev_fault = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_valid = 1'b0;
                continue;
            end
            if (bus_if.imem_req_valid) begin
                check("imem_addr", bus_if.imem_addr, exp_addr);
            end
            if (bus_if.inst_valid) begin
                check("pc_ready_while_inst_valid", {31'd0, bus_if.pc_ready}, 32'd0);
                if (prev_valid && !prev_ready) begin
                    check("hold_inst", bus_if.inst, prev_inst);
                    check("hold_inst_pc", bus_if.inst_pc, prev_pc);
                    check("hold_inst_fault", {31'd0, bus_if.inst_fault}, {31'd0, prev_fault});
                end
                if (bus_if.inst_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_inst: got pc=%h expected no instruction", bus_if.inst_pc);
                    end else begin
                        e = exp_q.pop_front();
                        $display("inst handshake pc=%h inst=%h fault=%0d", bus_if.inst_pc, bus_if.inst, bus_if.inst_fault);
                        check("inst", bus_if.inst, e.inst);
                        check("inst_pc", bus_if.inst_pc, e.pc);
                        check("inst_fault", {31'd0, bus_if.inst_fault}, {31'd0, e.fault});
                    end
                end
            end
            prev_valid = bus_if.inst_valid;
            prev_ready = bus_if.inst_ready;
            prev_inst  = bus_if.inst;
            prev_pc    = bus_if.inst_pc;
            prev_fault = bus_if.inst_fault;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation time limit expected end of test");
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        int          cyc;
        int          n;
        logic [31:0] pcs  [3];
        logic [31:0] words[3];
        pcs[0] = 32'h8000_0004; words[0] = 32'h0020_0113;
        pcs[1] = 32'h8000_0008; words[1] = 32'h0030_0193;
        pcs[2] = 32'h8000_000C; words[2] = 32'h0040_0213;

        rst = 1'b1;
        bus_if.imem_req_ready = 1'b1;
        bus_if.inst_ready     = 1'b1;
        bus_if.pc_valid       = 1'b0;
        bus_if.next_pc        = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_imem_req_valid", {31'd0, bus_if.imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'd0, bus_if.inst_valid}, 32'd0);
        check("rst_inst", bus_if.inst, 32'h0);
        check("rst_inst_pc", bus_if.inst_pc, 32'h0);
        check("rst_inst_fault", {31'd0, bus_if.inst_fault}, 32'd0);
        check("rst_pc_ready", {31'd0, bus_if.pc_ready}, 32'd0);
        check("rst_cur_pc", bus_if.imem_addr, 32'h8000_0000);

        // 1: first fetch, zero-wait memory
        mem_data = 32'h0010_0093;
        exp_addr = 32'h8000_0000;
        push_exp(32'h0010_0093, 32'h8000_0000, 1'b0);
        rst = 1'b0;
        wait_valid(cyc);
        check("t1_latency", cyc, 3);

        // 2: IDU stall for 5 cycles; stray pc_valid while stalled is ignored
        mem_data = 32'h0000_0513;
        exp_addr = 32'h8000_0004;
        push_exp(32'h0000_0513, 32'h8000_0004, 1'b0);
        give_pc(32'h8000_0004, 1'b0);
        wait_valid(cyc);
        check("t2_latency", cyc, 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus_if.pc_valid = 1'b1;
                bus_if.next_pc  = 32'h1234_5678;
            end
            #2;
            check("t2_inst_valid_held", {31'd0, bus_if.inst_valid}, 32'd1);
            check("t2_pc_ready_low", {31'd0, bus_if.pc_ready}, 32'd0);
        end
        @(negedge clk);
        bus_if.pc_valid   = 1'b0;
        bus_if.inst_ready = 1'b1;

        // 3: misaligned PC
        exp_addr = 32'h8000_0102;
        push_exp(32'h0000_0013, 32'h8000_0102, 1'b1);
        give_pc(32'h8000_0102, 1'b1);
        check("t3_no_req", {31'd0, bus_if.imem_req_valid}, 32'd0);
        wait_valid(cyc);
        check("t3_latency", cyc, 2);

        // 4a: memory silent -> timeout after 4 wait cycles
        mem_silent = 1'b1;
        exp_addr = 32'h8000_0008;
        push_exp(32'h0000_0013, 32'h8000_0008, 1'b1);
        give_pc(32'h8000_0008, 1'b1);
        wait_valid(cyc);
        check("t4a_latency", cyc, 6);

        // 4b: response on the 4th wait cycle is taken, no fault
        mem_silent = 1'b0;
        mem_lat  = 3;
        mem_data = 32'h00A0_0093;
        exp_addr = 32'h8000_000C;
        push_exp(32'h00A0_0093, 32'h8000_000C, 1'b0);
        give_pc(32'h8000_000C, 1'b1);
        wait_valid(cyc);
        check("t4b_latency", cyc, 6);

        // 5: bus error
        mem_lat  = 0;
        mem_err  = 1'b1;
        mem_data = 32'hDEAD_BEEF;
        exp_addr = 32'h8000_0010;
        push_exp(32'h0000_0013, 32'h8000_0010, 1'b1);
        give_pc(32'h8000_0010, 1'b1);
        wait_valid(cyc);
        check("t5_latency", cyc, 3);

        // 6: reset while in S_WAIT discards the fetch; loop restarts at RESET_PC
        mem_err  = 1'b0;
        mem_lat  = 5;
        exp_addr = 32'h8000_0020;
        give_pc(32'h8000_0020, 1'b1);
        repeat (2) @(negedge clk);
        rst      = 1'b1;
        exp_addr = 32'h8000_0000;
        mem_lat  = 0;
        mem_data = 32'h0000_0113;
        @(negedge clk);
        check("t6_rst_inst_valid", {31'd0, bus_if.inst_valid}, 32'd0);
        check("t6_rst_cur_pc", bus_if.imem_addr, 32'h8000_0000);
        push_exp(32'h0000_0113, 32'h8000_0000, 1'b0);
        rst = 1'b0;
        wait_valid(cyc);
        check("t6_latency", cyc, 3);
        for (int i = 0; i < 3; i++) begin
            mem_data = words[i];
            exp_addr = pcs[i];
            push_exp(words[i], pcs[i], 1'b0);
            give_pc(pcs[i], 1'b1);
            wait_valid(cyc);
            check("t6_loop_latency", cyc, 3);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
`ifdef NPC_IFU_PERF_CNT_EN
        check("perf_fetch_cnt", perf_fetch_cnt[31:0], 32'd4);
        check("perf_stall_cnt", perf_stall_cnt[31:0], 32'd4);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
